// File: rtl/zbus_demux_pipe.sv
// Registered 1-to-BN zbus de-multiplexer with one stage register.
// Optional unmatched-transfer sink and err pulse: ZBUS_DEMUX_ERR_EN.
module zbus_demux_pipe #(
  parameter int   BW = 8,
  parameter int   BN = 4,
  parameter int   SW = 2,
  parameter int   SL = 0,
  parameter logic DI = 1'bx
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            zi_vld,
  input  logic [BW-1:0]   zi_bus,
  output logic            zi_ack,
  output logic [BN-1:0]   zo_vld,
  output logic [BW*BN-1:0] zo_bus,
  input  logic [BN-1:0]   zo_ack,
  input  logic [BN-1:0]   enable
`ifdef ZBUS_DEMUX_ERR_EN
  ,
  output logic            err
`endif
);

  logic          r_vld;
  logic          r_err;
  logic [BW-1:0] r_bus;
  logic [SW-1:0] r_idx;

  logic [SW-1:0] w_idx;
  logic [SW-1:0] w_cap_idx;
  logic          w_cap_err;
  logic          w_match;
  logic          w_ack_sel;
  logic          w_done;
  logic          w_cap;
  logic          w_live;

  always_comb begin
    w_idx     = zi_bus[SL +: SW];
    w_match   = 1'b0;
    w_ack_sel = 1'b0;
    for (int i = 0; i < BN; i++) begin
      if (w_idx == SW'(i)) w_match = enable[i];
      if (r_idx == SW'(i)) w_ack_sel = zo_ack[i];
    end
  end

`ifdef ZBUS_DEMUX_ERR_EN
  assign w_cap_idx = w_idx;
  assign w_cap_err = ~w_match;
  assign err       = rst & r_vld & r_err;
`else
  // Unmatched transfers fall through to port 0.
  assign w_cap_idx = w_match ? w_idx : '0;
  assign w_cap_err = 1'b0;
`endif

  assign w_done = r_vld & (r_err | w_ack_sel);
  assign zi_ack = rst & (~r_vld | w_done);
  assign w_cap  = zi_vld & zi_ack;
  assign w_live = rst & r_vld & ~r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
    end else if (w_cap) begin
      r_vld <= 1'b1;
      r_err <= w_cap_err;
      r_bus <= zi_bus;
      r_idx <= w_cap_idx;
    end else if (w_done) begin
      r_vld <= 1'b0;
    end
  end

  for (genvar g = 0; g < BN; g++) begin : g_port
    assign zo_vld[g] = w_live & (r_idx == SW'(g));
    assign zo_bus[g*BW +: BW] = zo_vld[g] ? r_bus : {BW{DI}};
  end

endmodule

// File: tb/tb_zbus_demux_pipe.sv
// Random-stimulus bench for zbus_demux_pipe, BN=4 and BN=3 instances.
// Compares against a slot-based transfer model every cycle.
module tb_zbus_demux_pipe;

  localparam int BW = 8;
  localparam int SW = 2;
  localparam int SL = 0;
`ifdef ZBUS_DEMUX_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          zi_vld;
  logic [BW-1:0] zi_bus;
  logic [3:0]    enable;
  logic [3:0]    ack_a;
  logic [2:0]    ack_b;
  logic          zi_ack_a, zi_ack_b;
  logic [3:0]    zo_vld_a;
  logic [2:0]    zo_vld_b;
  logic [31:0]   zo_bus_a;
  logic [23:0]   zo_bus_b;
  logic          err_a, err_b;

  zbus_demux_pipe #(.BW(BW), .BN(4), .SW(SW), .SL(SL)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .zi_vld (zi_vld),
    .zi_bus (zi_bus),
    .zi_ack (zi_ack_a),
    .zo_vld (zo_vld_a),
    .zo_bus (zo_bus_a),
    .zo_ack (ack_a),
    .enable (enable)
`ifdef ZBUS_DEMUX_ERR_EN
    ,
    .err    (err_a)
`endif
  );

  zbus_demux_pipe #(.BW(BW), .BN(3), .SW(SW), .SL(SL)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .zi_vld (zi_vld),
    .zi_bus (zi_bus),
    .zi_ack (zi_ack_b),
    .zo_vld (zo_vld_b),
    .zo_bus (zo_bus_b),
    .zo_ack (ack_b),
    .enable (enable[2:0])
`ifdef ZBUS_DEMUX_ERR_EN
    ,
    .err    (err_b)
`endif
  );

`ifndef ZBUS_DEMUX_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // One held transfer per DUT; port -1 means sunk as unmatched.
  bit          m_full [2];
  logic [7:0]  m_data [2];
  int          m_port [2];
  int          bn     [2] = '{4, 3};

  function automatic bit ackbit(int k, int p);
    if (k == 0) return ack_a[p];
    return ack_b[p];
  endfunction

  function automatic bit m_done(int k);
    if (!m_full[k]) return 1'b0;
    if (m_port[k] < 0) return 1'b1;
    return ackbit(k, m_port[k]);
  endfunction

  task automatic check_dut(int k);
    logic [63:0] eb, ev, ob, ov;
    logic        ea, ee, oa, oe;
    string       s;
    eb = '0;
    for (int j = 0; j < bn[k] * BW; j++) eb[j] = 1'bx;
    ev = '0;
    ea = 1'b0;
    ee = 1'b0;
    if (rst) begin
      ea = !m_full[k] || m_done(k);
      if (m_full[k] && m_port[k] >= 0) begin
        ev[m_port[k]] = 1'b1;
        eb[m_port[k]*BW +: BW] = m_data[k];
      end
      ee = m_full[k] && m_port[k] < 0;
    end
    if (k == 0) begin
      ob = 64'(zo_bus_a); ov = 64'(zo_vld_a);
      oa = zi_ack_a;      oe = err_a;
    end else begin
      ob = 64'(zo_bus_b); ov = 64'(zo_vld_b);
      oa = zi_ack_b;      oe = err_b;
    end
    s = (k == 0) ? "bn4" : "bn3";
    chk({s, ".zi_ack"}, 64'(oa), 64'(ea));
    chk({s, ".zo_vld"}, ov, ev);
    chk({s, ".zo_bus"}, ob, eb);
    if (ERR) chk({s, ".err"}, 64'(oe), 64'(ee));
  endtask

  task automatic update_model(int k);
    bit done, acc, unm;
    int idx;
    if (!rst) begin
      m_full[k] = 1'b0;
      return;
    end
    done = m_done(k);
    acc  = !m_full[k] || done;
    if (zi_vld && acc) begin
      idx = int'(zi_bus[SL +: SW]);
      unm = (idx >= bn[k]) || !enable[idx];
      m_port[k] = unm ? (ERR ? -1 : 0) : idx;
      m_data[k] = zi_bus;
      m_full[k] = 1'b1;
    end else if (done) begin
      m_full[k] = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b0;
    zi_vld = 1'b0;
    zi_bus = '0;
    enable = 4'hF;
    ack_a  = '0;
    ack_b  = '0;
    m_full = '{0, 0};
    m_port = '{0, 0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst    = (cyc < 3) ? 1'b0 : ($urandom_range(0, 59) != 0);
      zi_vld = ($urandom_range(0, 3) != 0);
      zi_bus = 8'($urandom);
      if (cyc < 400)      enable = 4'hF;
      else if (cyc < 800) enable = 4'b1101;
      else                enable = 4'($urandom);
      if (cyc < 200) begin
        ack_a = 4'hF;
        ack_b = 3'h7;
      end else if (cyc < 1000) begin
        ack_a = 4'($urandom);
        ack_b = 3'($urandom);
      end else begin
        // sparse acks produce long holds
        ack_a = 4'($urandom) & 4'($urandom) & 4'($urandom);
        ack_b = 3'($urandom) & 3'($urandom) & 3'($urandom);
      end
      #1;
      check_dut(0);
      check_dut(1);
      @(posedge clk);
      update_model(0);
      update_model(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
